ignition_start_controller: RTL and testbench

IGNITION_START_CONTROLLER -- requirements
Module: ignition_start_controller

---
 rtl/ignition_start_controller.sv | 129 ++++++++++++
 tb/tb_ignition_start_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ignition_start_controller.sv
// Ignition/start sequencer: key, start button and engine feedback drive a
// five-state FSM with crank timeout lockout, plus an independent chime generator.
module ignition_start_controller #(
  parameter int CRANK_MAX = 200,
  parameter int P1_HALF   = 4,
  parameter int P2_HALF   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  input  logic       start_btn,
  input  logic       start_permit,
  input  logic       eng_run,
  input  logic       chime,
  input  logic       warn_pri1,
  input  logic       warn_pri2,
  output logic       ign_on,
  output logic       crank,
  output logic       fault,
  output logic       chime_out,
  output logic [2:0] state
);

  // state      | meaning
  // ST_OFF     | key out, all drives off
  // ST_ARMED   | ignition on, waiting for a permitted start edge
  // ST_CRANK   | starter engaged, crank timer running
  // ST_RUN     | engine running, start button ignored
  // ST_LOCKOUT | crank timed out, only key-off recovers
  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CRANK   = 3'd2,
    ST_RUN     = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  localparam int CW      = (CRANK_MAX > 1) ? $clog2(CRANK_MAX + 1) : 1;
  localparam int HMAX    = (P1_HALF > P2_HALF) ? P1_HALF : P2_HALF;
  localparam int HW      = (HMAX > 1) ? $clog2(HMAX + 1) : 1;
  localparam logic [CW-1:0] CRANK_LAST = CW'(CRANK_MAX - 1);

  state_t          state_q;
  state_t          state_nxt;
  logic            btn_q;
  logic            start_edge;
  logic [CW-1:0]   crank_cnt;

  logic [1:0]      rate_sel;
  logic [1:0]      sel_q;
  logic [HW-1:0]   half_m1;
  logic [HW-1:0]   chime_cnt;

  assign state      = state_q;
  assign start_edge = start_btn & ~btn_q;

  always_comb begin
    state_nxt = state_q;
    if (!key) begin
      state_nxt = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:     state_nxt = ST_ARMED;
        ST_ARMED:   if (start_edge && start_permit) state_nxt = ST_CRANK;
        ST_CRANK: begin
          if (eng_run)                          state_nxt = ST_RUN;
          else if (!start_permit || !start_btn) state_nxt = ST_ARMED;
          else if (crank_cnt == CRANK_LAST)     state_nxt = ST_LOCKOUT;
        end
        ST_RUN:     if (!eng_run) state_nxt = ST_ARMED;
        ST_LOCKOUT: state_nxt = ST_LOCKOUT;
        default:    state_nxt = ST_OFF;
      endcase
    end
  end

  // Outputs are registered from the next state so they always match state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_OFF;
      btn_q     <= 1'b0;
      crank_cnt <= '0;
      ign_on    <= 1'b0;
      crank     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q <= state_nxt;
      btn_q   <= start_btn;
      ign_on  <= (state_nxt == ST_ARMED) || (state_nxt == ST_CRANK) || (state_nxt == ST_RUN);
      crank   <= (state_nxt == ST_CRANK);
      fault   <= (state_nxt == ST_LOCKOUT);
      if (state_nxt == ST_CRANK && state_q != ST_CRANK)
        crank_cnt <= '0;
      else if (state_q == ST_CRANK && crank_cnt != CRANK_LAST)
        crank_cnt <= crank_cnt + 1'b1;
    end
  end

  always_comb begin
    if (warn_pri1)              rate_sel = 2'd1;
    else if (warn_pri2 || chime) rate_sel = 2'd2;
    else                        rate_sel = 2'd0;
    half_m1 = (rate_sel == 2'd1) ? HW'(P1_HALF - 1) : HW'(P2_HALF - 1);
  end

  // A rate change restarts the square wave high so the new cadence is heard at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= 2'd0;
      chime_cnt <= '0;
      chime_out <= 1'b0;
    end else begin
      sel_q <= rate_sel;
      if (rate_sel == 2'd0) begin
        chime_cnt <= '0;
        chime_out <= 1'b0;
      end else if (rate_sel != sel_q) begin
        chime_cnt <= '0;
        chime_out <= 1'b1;
      end else if (chime_cnt == half_m1) begin
        chime_cnt <= '0;
        chime_out <= ~chime_out;
      end else begin
        chime_cnt <= chime_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ignition_start_controller.sv
// Directed plus randomized bench for ignition_start_controller against a
// behavioural model built from elapsed-time rules.
module tb_ignition_start_controller;
  localparam int CRANK_MAX = 200;
  localparam int P1 = 4;
  localparam int P2 = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key = 1'b0, start_btn = 1'b0, start_permit = 1'b0, eng_run = 1'b0;
  logic chime = 1'b0, warn_pri1 = 1'b0, warn_pri2 = 1'b0;
  logic ign_on, crank, fault, chime_out;
  logic [2:0] state;

  ignition_start_controller #(.CRANK_MAX(CRANK_MAX), .P1_HALF(P1), .P2_HALF(P2)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .start_btn(start_btn),
    .start_permit(start_permit), .eng_run(eng_run), .chime(chime),
    .warn_pri1(warn_pri1), .warn_pri2(warn_pri2), .ign_on(ign_on),
    .crank(crank), .fault(fault), .chime_out(chime_out), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: state code, time spent cranking, time since chime rate change.
  int m_state;
  bit m_btn_prev;
  int m_crank_t;
  int m_rate;
  int m_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_state = 0; m_btn_prev = 0; m_crank_t = 0; m_rate = 0; m_t = 0;
  endtask

  task automatic model_step();
    bit se;
    int nxt;
    int new_rate;
    se  = start_btn && !m_btn_prev;
    nxt = m_state;
    if (!key) nxt = 0;
    else begin
      case (m_state)
        0: nxt = 1;
        1: if (se && start_permit) nxt = 2;
        2: if (eng_run) nxt = 3;
           else if (!start_permit || !start_btn) nxt = 1;
           else if (m_crank_t >= CRANK_MAX) nxt = 4;
        3: if (!eng_run) nxt = 1;
        default: nxt = m_state;
      endcase
    end
    if (nxt == 2) m_crank_t = (m_state == 2) ? m_crank_t + 1 : 1;
    m_state = nxt;
    m_btn_prev = start_btn;
    new_rate = warn_pri1 ? P1 : ((warn_pri2 || chime) ? P2 : 0);
    if (new_rate != m_rate) begin m_rate = new_rate; m_t = 0; end
    else m_t++;
  endtask

  task automatic compare_all();
    int exp_ch;
    exp_ch = (m_rate == 0) ? 0 : (((m_t / m_rate) % 2) == 0 ? 1 : 0);
    check("state", state, m_state);
    check("ign_on", ign_on, (m_state >= 1 && m_state <= 3) ? 1 : 0);
    check("crank", crank, (m_state == 2) ? 1 : 0);
    check("fault", fault, (m_state == 4) ? 1 : 0);
    check("chime_out", chime_out, exp_ch);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Called just after an edge: pulses reset entirely between clock edges.
  task automatic async_reset();
    #3 rst_n = 1'b0;
    #1;
    check("arst_crank", crank, 0);
    check("arst_ign_on", ign_on, 0);
    check("arst_state", state, 0);
    check("arst_chime", chime_out, 0);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int n_cr;
    int hi;
    int rises;
    logic prev;

    model_reset();
    #2;
    check("rst_state", state, 0);
    check("rst_ign_on", ign_on, 0);
    check("rst_crank", crank, 0);
    check("rst_fault", fault, 0);
    check("rst_chime", chime_out, 0);
    @(negedge clk) rst_n = 1'b1;

    // normal start
    key = 1; start_permit = 1;
    repeat (4) cycle();
    check("armed", state, 1);
    start_btn = 1; n_cr = 0;
    for (int i = 0; i < 15; i++) begin cycle(); if (crank) n_cr++; end
    eng_run = 1;
    cycle();
    check("start_run", state, 3);
    check("start_crank_len", n_cr, 15);
    check("start_ign", ign_on, 1);
    start_btn = 0; cycle(); start_btn = 1; cycle();
    check("run_btn_ignored", state, 3);
    eng_run = 0; cycle();
    check("stall_armed", state, 1);

    // crank timeout
    start_btn = 0; cycle();
    start_btn = 1; n_cr = 0;
    for (int i = 0; i < 220; i++) begin cycle(); if (crank) n_cr++; end
    check("timeout_crank_len", n_cr, CRANK_MAX);
    check("timeout_state", state, 4);
    check("timeout_fault", fault, 1);
    repeat (4) begin start_btn = 0; cycle(); start_btn = 1; cycle(); end
    check("lockout_retry", state, 4);
    key = 0; cycle();
    check("lockout_exit_state", state, 0);
    check("lockout_exit_fault", fault, 0);

    // permit denied
    key = 1; start_btn = 0; start_permit = 0;
    repeat (2) cycle();
    start_btn = 1;
    repeat (3) cycle();
    check("deny_state", state, 1);
    check("deny_crank", crank, 0);
    start_permit = 1;
    repeat (3) cycle();
    check("deny_held_state", state, 1);

    // key-off wins over engine-run in crank
    start_btn = 0; cycle();
    start_btn = 1; cycle();
    check("simul_crank", state, 2);
    key = 0; eng_run = 1; cycle();
    check("simul_off", state, 0);
    eng_run = 0; key = 1; start_btn = 0;
    cycle();

    // chime rates
    warn_pri2 = 1; hi = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 64; i++) begin
      cycle();
      if (i == 0) check("p2_first_high", chime_out, 1);
      else if (chime_out && !prev) rises++;
      if (chime_out) hi++;
      prev = chime_out;
    end
    check("p2_high_cycles", hi, 32);
    check("p2_rises", rises, 1);
    warn_pri1 = 1; hi = 0; rises = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (i == 0) check("p1_restart_high", chime_out, 1);
      else if (chime_out && !prev) rises++;
      if (chime_out) hi++;
      prev = chime_out;
    end
    check("p1_high_cycles", hi, 8);
    check("p1_rises", rises, 1);
    warn_pri1 = 0; warn_pri2 = 0; cycle();
    check("chime_off", chime_out, 0);

    // async reset mid-crank
    start_permit = 1; start_btn = 0;
    repeat (2) cycle();
    start_btn = 1;
    repeat (5) cycle();
    check("pre_arst_crank", state, 2);
    async_reset();
    repeat (3) cycle();

    // randomized
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3)  key = ~key;
      if ($urandom_range(0, 99) < 10) start_btn = ~start_btn;
      if ($urandom_range(0, 99) < 5)  start_permit = ~start_permit;
      if ($urandom_range(0, 99) < 4)  eng_run = ~eng_run;
      if ($urandom_range(0, 99) < 3)  chime = ~chime;
      if ($urandom_range(0, 99) < 3)  warn_pri1 = ~warn_pri1;
      if ($urandom_range(0, 99) < 3)  warn_pri2 = ~warn_pri2;
      if ($urandom_range(0, 499) == 0) async_reset();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
